// File: rtl/clock_ratio_monitor.sv
// clock_ratio_monitor: measures a divided clock's period and high time in the reference domain and checks it against io_div
module clock_ratio_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             io_clock_in,
    input  logic [7:0]       io_div,
    input  logic             io_en,
    output logic [CNT_W-1:0] io_period,
    output logic [CNT_W-1:0] io_high,
    output logic             io_valid,
    output logic             io_locked,
    output logic             io_err,
    output logic             io_timeout
);
    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W:0] TOL_V = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0] LOCK_V = MC_W'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise, match, timed_out, div_chg;
    logic [CNT_W-1:0]       cnt, hcnt, cnt_inc, hcnt_inc;
    logic [MC_W-1:0]        match_cnt, mc_inc;
    logic [7:0]             div_q;
    logic [CNT_W:0]         cnt_x, div_ref, diff;

    // edge detect, saturating increments and the tolerance compare at CNT_W+1 bits so nothing wraps
    always_comb begin
        s         = sync[SYNC_STAGES-1];
        rise      = s & ~s_d;
        cnt_inc   = &cnt ? cnt : cnt + 1'b1;
        hcnt_inc  = (s && !(&hcnt)) ? hcnt + 1'b1 : hcnt;
        cnt_x     = {1'b0, cnt};
        div_ref   = (div_q == 8'd0) ? (CNT_W + 1)'(1) : (CNT_W + 1)'(div_q);
        diff      = (cnt_x > div_ref) ? cnt_x - div_ref : div_ref - cnt_x;
        match     = diff <= TOL_V;
        mc_inc    = (match_cnt >= LOCK_V) ? LOCK_V : match_cnt + 1'b1;
        timed_out = cnt >= TIMEOUT_V;
        div_chg   = io_div != div_q;
    end

    // synchronizer chain for the asynchronous input, its delayed copy and the registered ratio
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            s_d   <= 1'b0;
            div_q <= '0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], io_clock_in};
            s_d   <= s;
            div_q <= io_div;
        end
    end

    // measurement FSM: disable wins, then rise wins over timeout; a ratio change drops lock without an error
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            match_cnt  <= '0;
            io_period  <= '0;
            io_high    <= '0;
            io_valid   <= 1'b0;
            io_locked  <= 1'b0;
            io_err     <= 1'b0;
            io_timeout <= 1'b0;
        end else begin
            io_valid <= 1'b0;
            io_err   <= 1'b0;
            if (!io_en) begin
                state      <= IDLE;
                cnt        <= '0;
                hcnt       <= '0;
                match_cnt  <= '0;
                io_locked  <= 1'b0;
                io_timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ARM;
                    ARM: begin
                        if (rise) begin
                            cnt        <= CNT_W'(1);
                            hcnt       <= CNT_W'(1);
                            io_timeout <= 1'b0;
                            state      <= MEASURE;
                        end else if (timed_out) begin
                            io_timeout <= 1'b1;
                            io_locked  <= 1'b0;
                            match_cnt  <= '0;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            io_period  <= cnt;
                            io_high    <= hcnt;
                            io_valid   <= 1'b1;
                            cnt        <= CNT_W'(1);
                            hcnt       <= CNT_W'(1);
                            io_timeout <= 1'b0;
                            if (match) begin
                                match_cnt <= mc_inc;
                                io_locked <= io_locked | (mc_inc == LOCK_V);
                            end else begin
                                match_cnt <= '0;
                                io_locked <= 1'b0;
                                io_err    <= io_locked;
                            end
                        end else if (timed_out) begin
                            io_timeout <= 1'b1;
                            io_locked  <= 1'b0;
                            match_cnt  <= '0;
                            cnt        <= '0;
                            hcnt       <= '0;
                            state      <= ARM;
                        end else begin
                            cnt  <= cnt_inc;
                            hcnt <= hcnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (div_chg) begin
                    match_cnt <= '0;
                    io_locked <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_clock_ratio_monitor.sv
// tb_clock_ratio_monitor: directed vectors for the divided-clock monitor
module tb_clock_ratio_monitor;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1024;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             io_clock_in = 1'b0;
    logic             io_en = 1'b0;
    logic [7:0]       io_div = 8'd0;
    logic [CNT_W-1:0] io_period, io_high;
    logic             io_valid, io_locked, io_err, io_timeout;

    int   checks = 0, errors = 0;
    int   cyc_n = 0, n_valid = 0, n_err = 0, last_period = 0, last_high = 0, valid_cyc = 0;
    int   lock_idx = 0, to_cyc = 0;
    logic lock_seen = 1'b0, to_seen = 1'b0, to_locked = 1'b0;

    clock_ratio_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .io_clock_in(io_clock_in), .io_div(io_div), .io_en(io_en),
        .io_period(io_period), .io_high(io_high), .io_valid(io_valid), .io_locked(io_locked),
        .io_err(io_err), .io_timeout(io_timeout)
    );

    always #5 clock = ~clock;

    // observe outputs just after each active edge and log pulses and first sightings
    always @(posedge clock) begin
        #1;
        cyc_n++;
        if (io_valid) begin
            n_valid++;
            last_period = int'(io_period);
            last_high   = int'(io_high);
            valid_cyc   = cyc_n;
        end
        if (io_err) n_err++;
        if (io_locked && !lock_seen) begin
            lock_seen = 1'b1;
            lock_idx  = n_valid;
        end
        if (io_timeout && !to_seen) begin
            to_seen   = 1'b1;
            to_cyc    = cyc_n;
            to_locked = io_locked;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v);
        io_clock_in = v;
        @(negedge clock);
    endtask

    task automatic per(input int p, input int h);
        for (int i = 0; i < h; i++) cyc(1'b1);
        for (int i = 0; i < p - h; i++) cyc(1'b0);
    endtask

    initial begin
        io_div = 8'd4;
        io_en  = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_outputs", {io_period, io_high, io_valid, io_locked, io_err, io_timeout}, 0);
        reset_n = 1'b1;
        cyc(1'b0);
        cyc(1'b0);

        repeat (7) per(4, 2);
        check("t1_valids", n_valid, 6);
        check("t1_period", last_period, 4);
        check("t1_high", last_high, 2);
        check("t1_lock_on_valid", lock_idx, 4);
        check("t1_locked", io_locked, 1);
        check("t1_no_err", n_err, 0);

        n_err = 0;
        repeat (3) per(6, 3);
        check("t2_period", last_period, 6);
        check("t2_high", last_high, 3);
        check("t2_one_err", n_err, 1);
        check("t2_unlocked", io_locked, 0);

        repeat (6) per(4, 2);
        check("t3_relocked", io_locked, 1);
        to_seen = 1'b0;
        repeat (1100) cyc(1'b0);
        check("t3_timeout_seen", to_seen, 1);
        check("t3_timeout_delay", to_cyc - valid_cyc, TIMEOUT);
        check("t3_timeout_unlock", to_locked, 0);
        check("t3_timeout_level", io_timeout, 1);
        n_valid   = 0;
        lock_seen = 1'b0;
        per(4, 2);
        check("t3_timeout_clear", io_timeout, 0);
        check("t3_arm_no_valid", n_valid, 0);
        repeat (3) per(4, 2);
        check("t3_not_yet_locked", io_locked, 0);
        per(4, 2);
        check("t3_lock_regained", io_locked, 1);
        check("t3_lock_on_valid", lock_idx, 4);

        io_div    = 8'd5;
        n_err     = 0;
        per(5, 2); per(4, 2); per(6, 3); per(5, 2);
        per(6, 3); per(4, 2); per(5, 2); per(5, 2);
        check("t4_jitter_locked", io_locked, 1);
        check("t4_jitter_no_err", n_err, 0);
        check("t4_jitter_period", last_period, 5);
        per(7, 3);
        per(5, 2);
        check("t4_err_on_7", n_err, 1);
        check("t4_period_7", last_period, 7);
        check("t4_unlocked", io_locked, 0);

        cyc(1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_async_clear", {io_period, io_high, io_valid, io_locked, io_err, io_timeout}, 0);
        io_clock_in = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        n_valid = 0;
        per(5, 2);
        check("t5_first_rise_arms", n_valid, 0);
        per(5, 2);
        check("t5_second_valid", n_valid, 1);
        check("t5_period", last_period, 5);
        check("t5_high", last_high, 2);

        repeat (4) per(5, 2);
        check("t6_locked", io_locked, 1);
        io_en = 1'b0;
        @(posedge clock);
        #1;
        check("t6_en_drop_unlock", io_locked, 0);
        check("t6_period_held", io_period, 5);
        @(negedge clock);
        io_div = 8'd4;
        io_en  = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        repeat (6) per(4, 2);
        check("t6_relock_div4", io_locked, 1);
        n_err  = 0;
        io_div = 8'd8;
        @(posedge clock);
        #1;
        check("t6_div_change_unlock", io_locked, 0);
        @(negedge clock);
        repeat (3) per(4, 2);
        check("t6_div_change_no_err", n_err, 0);
        check("t6_stays_unlocked", io_locked, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
